reg_pipe_vr: RTL

// - Parametrised elastic register pipeline: WIDTH-bit payload through DEPTH register stages.
// - Uses a valid/ready handshake on both sides, bubble collapsing, flush, and an occupancy count.
// - Next-generation N-bit register. The enable becomes real flow control (ready); width and depth are generic.
// - Sits between any producer/consumer pair that needs fixed-latency retiming with backpressure.

---
 rtl/reg_pipe_pkg.sv | 23 ++
 rtl/reg_pipe_stage.sv | 67 ++++++
 rtl/reg_pipe_vr.sv | 127 ++++++++++++
 3 files changed

// File: rtl/reg_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe_pkg
// Brief    : Shared constants and helpers for the reg_pipe_vr elastic pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package reg_pipe_pkg;

  localparam logic RESET_ACTIVE = 1'b0;

  // Widest payload the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 1024;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] bits);
    return ^bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe_stage
// Brief    : One elastic register stage (valid + data, parity bit when
//            REG_PIPE_PARITY_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_adv_out,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
`ifdef REG_PIPE_PARITY_EN
  input  logic             i_par,
  output logic             o_par,
`endif
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_adv
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
`ifdef REG_PIPE_PARITY_EN
  logic             r_par;
`endif

  // i_adv_out means the downstream slot can take a beat this cycle.
  assign o_adv   = r_valid & i_adv_out;
  assign o_valid = r_valid;
  assign o_data  = r_data;
`ifdef REG_PIPE_PARITY_EN
  assign o_par   = r_par;
`endif

  always_ff @(posedge clk) begin
    if (reset_n == RESET_ACTIVE) begin
      r_valid <= 1'b0;
      r_data  <= '0;
`ifdef REG_PIPE_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end else if (o_adv) begin
        r_valid <= 1'b0;
      end
      if (i_load) begin
        r_data <= i_data;
`ifdef REG_PIPE_PARITY_EN
        r_par  <= i_par;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_pipe_vr.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe_vr
// Brief    : WIDTH x DEPTH elastic register pipeline with valid/ready,
//            bubble collapsing, flush and occupancy count. Optional sticky
//            parity check enabled by REG_PIPE_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_pipe_vr
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      io_in_valid,
  output logic                      io_in_ready,
  input  logic [WIDTH-1:0]          io_in_bits,
  output logic                      io_out_valid,
  input  logic                      io_out_ready,
  output logic [WIDTH-1:0]          io_out_bits,
  input  logic                      io_flush,
`ifdef REG_PIPE_PARITY_EN
  output logic                      io_par_err,
`endif
  output logic [cnt_w(DEPTH)-1:0]   io_count
);

  localparam int c_cnt_w = cnt_w(DEPTH);

  logic [DEPTH-1:0]   w_valid;
  logic [DEPTH-1:0]   w_adv;
  logic [DEPTH-1:0]   w_space;
  logic [WIDTH-1:0]   w_data [DEPTH];
  logic               w_in_fire;
  logic               w_out_fire;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic [c_cnt_w-1:0] r_count;
`ifdef REG_PIPE_PARITY_EN
  logic [DEPTH-1:0]   w_par;
  logic               w_in_par;
  logic               r_par_err;
`endif

  // Ready is combinational from the advance chain: no skid storage.
  assign io_in_ready  = (reset_n != RESET_ACTIVE) & ~io_flush & (~w_valid[0] | w_adv[0]);
  assign w_in_fire    = io_in_valid & io_in_ready;
  assign w_out_fire   = w_adv[DEPTH-1];
  assign io_out_valid = w_valid[DEPTH-1];
  assign io_out_bits  = w_data[DEPTH-1];
  assign io_count     = r_count;
`ifdef REG_PIPE_PARITY_EN
  assign w_in_par     = even_par(PAR_MAX_W'(io_in_bits));
  assign io_par_err   = r_par_err;
`endif

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    logic             w_load;
    logic [WIDTH-1:0] w_up_data;
`ifdef REG_PIPE_PARITY_EN
    logic             w_up_par;
`endif

    if (s == 0) begin : g_first
      assign w_load    = w_in_fire;
      assign w_up_data = io_in_bits;
`ifdef REG_PIPE_PARITY_EN
      assign w_up_par  = w_in_par;
`endif
    end else begin : g_rest
      assign w_load    = w_adv[s-1];
      assign w_up_data = w_data[s-1];
`ifdef REG_PIPE_PARITY_EN
      assign w_up_par  = w_par[s-1];
`endif
    end

    // A slot has room if it is empty or is itself draining this cycle.
    if (s == DEPTH - 1) begin : g_last
      assign w_space[s] = io_out_ready;
    end else begin : g_inner
      assign w_space[s] = ~w_valid[s+1] | w_adv[s+1];
    end

    reg_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_load    (w_load),
      .i_adv_out (w_space[s]),
      .i_flush   (io_flush),
      .i_data    (w_up_data),
`ifdef REG_PIPE_PARITY_EN
      .i_par     (w_up_par),
      .o_par     (w_par[s]),
`endif
      .o_valid   (w_valid[s]),
      .o_data    (w_data[s]),
      .o_adv     (w_adv[s])
    );
  end

  assign w_count_nxt = r_count + c_cnt_w'(w_in_fire) - c_cnt_w'(w_out_fire);

  always_ff @(posedge clk) begin
    if (reset_n == RESET_ACTIVE || io_flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

`ifdef REG_PIPE_PARITY_EN
  // Sticky until reset; flush intentionally leaves it alone.
  always_ff @(posedge clk) begin
    if (reset_n == RESET_ACTIVE) begin
      r_par_err <= 1'b0;
    end else if (w_out_fire && (even_par(PAR_MAX_W'(io_out_bits)) != w_par[DEPTH-1])) begin
      r_par_err <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
